// File: rtl/usr_irq_responder.sv
// rtl/usr_irq_responder.sv - user-interrupt responder: request FIFO, delayed ack/fail, status counters
module usr_irq_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             axil_aclk,
  input  logic             axil_areset,
  input  logic             usr_irq_in_vld,
  input  logic [11:0]      usr_irq_in_vec,
  input  logic [7:0]       usr_irq_in_fnc,
  output logic             usr_irq_out_ack,
  output logic             usr_irq_out_fail,
  input  logic             cfg_enable,
  input  logic [7:0]       cfg_ack_delay,
  input  logic [7:0]       cfg_max_fnc,
  input  logic             cfg_force_fail,
  output logic             stat_busy,
  output logic [2:0]       stat_level,
  output logic [11:0]      stat_last_vec,
  output logic [7:0]       stat_last_fnc,
  output logic [CNT_W-1:0] stat_ack_cnt,
  output logic [CNT_W-1:0] stat_fail_cnt,
  output logic [CNT_W-1:0] stat_drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [19:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         wait_q, wait_d;
  logic               fail_q, fail_d;
  logic [11:0]        cur_vec_q, cur_vec_d;
  logic [7:0]         cur_fnc_q, cur_fnc_d;
  logic [11:0]        last_vec_q, last_vec_d;
  logic [7:0]         last_fnc_q, last_fnc_d;
  logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               pop;
  logic               push;
  logic               drop;
  logic [19:0]        head;
  logic               ack_pulse;
  logic               fail_pulse;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign head = mem_q[rd_ptr_q];
  assign pop  = (state_q == S_IDLE) && (level_q != '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push = usr_irq_in_vld && cfg_enable &&
                ((level_q < LVL_W'(FIFO_DEPTH)) || pop);
  assign drop = usr_irq_in_vld && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    fail_d     = fail_q;
    cur_vec_d  = cur_vec_q;
    cur_fnc_d  = cur_fnc_q;
    ack_pulse  = 1'b0;
    fail_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_vec_d = head[19:8];
          cur_fnc_d = head[7:0];
          fail_d    = cfg_force_fail || (head[7:0] > cfg_max_fnc);
          wait_d    = cfg_ack_delay;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 8'd0) begin
          state_d = S_RESP;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_RESP: begin
        ack_pulse  = !fail_q;
        fail_pulse = fail_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    last_vec_d = last_vec_q;
    last_fnc_d = last_fnc_q;
    ack_cnt_d  = ack_cnt_q;
    fail_cnt_d = fail_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == S_RESP) begin
      last_vec_d = cur_vec_q;
      last_fnc_d = cur_fnc_q;
      if (fail_q) begin
        fail_cnt_d = sat_inc(fail_cnt_q);
      end else begin
        ack_cnt_d = sat_inc(ack_cnt_q);
      end
    end
    if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge axil_aclk or posedge axil_areset) begin
    if (axil_areset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wait_q     <= '0;
      fail_q     <= 1'b0;
      cur_vec_q  <= '0;
      cur_fnc_q  <= '0;
      last_vec_q <= '0;
      last_fnc_q <= '0;
      ack_cnt_q  <= '0;
      fail_cnt_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wait_q     <= wait_d;
      fail_q     <= fail_d;
      cur_vec_q  <= cur_vec_d;
      cur_fnc_q  <= cur_fnc_d;
      last_vec_q <= last_vec_d;
      last_fnc_q <= last_fnc_d;
      ack_cnt_q  <= ack_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {usr_irq_in_vec, usr_irq_in_fnc};
      end
    end
  end

  // Pulses decode straight from state so an async reset kills them at once.
  assign usr_irq_out_ack  = ack_pulse;
  assign usr_irq_out_fail = fail_pulse;
  assign stat_busy        = (level_q != '0) || (state_q != S_IDLE);
  assign stat_level       = 3'(level_q);
  assign stat_last_vec    = last_vec_q;
  assign stat_last_fnc    = last_fnc_q;
  assign stat_ack_cnt     = ack_cnt_q;
  assign stat_fail_cnt    = fail_cnt_q;
  assign stat_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_usr_irq_responder.sv
// tb/tb_usr_irq_responder.sv - randomized bench for usr_irq_responder against a queue-based model
module tb_usr_irq_responder;

  localparam int DEPTH = 4;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [11:0]   vec = '0;
  logic [7:0]    fnc = '0;
  logic          ack, fail;
  logic          en = 1'b1;
  logic [7:0]    dly = '0;
  logic [7:0]    maxf = 8'hff;
  logic          force_f = 1'b0;
  logic          busy;
  logic [2:0]    level;
  logic [11:0]   last_vec;
  logic [7:0]    last_fnc;
  logic [CW-1:0] ack_cnt, fail_cnt, drop_cnt;

  usr_irq_responder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .axil_aclk        (clk),
    .axil_areset      (rst),
    .usr_irq_in_vld   (vld),
    .usr_irq_in_vec   (vec),
    .usr_irq_in_fnc   (fnc),
    .usr_irq_out_ack  (ack),
    .usr_irq_out_fail (fail),
    .cfg_enable       (en),
    .cfg_ack_delay    (dly),
    .cfg_max_fnc      (maxf),
    .cfg_force_fail   (force_f),
    .stat_busy        (busy),
    .stat_level       (level),
    .stat_last_vec    (last_vec),
    .stat_last_fnc    (last_fnc),
    .stat_ack_cnt     (ack_cnt),
    .stat_fail_cnt    (fail_cnt),
    .stat_drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: a queue of waiting requests plus one request in service,
  // whose response is due at an absolute cycle number.
  logic [19:0] mq[$];
  bit          have_svc;
  int          t_resp;
  int          cyc;
  logic [11:0] svc_vec;
  logic [7:0]  svc_fnc;
  bit          svc_fail;
  int          m_ack, m_fail, m_drop;
  int          m_last_vec, m_last_fnc;

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    have_svc   = 0;
    t_resp     = 0;
    m_ack      = 0;
    m_fail     = 0;
    m_drop     = 0;
    m_last_vec = 0;
    m_last_fnc = 0;
  endtask

  task automatic model_step();
    bit          pop_now;
    int          sz0;
    logic [19:0] e;
    sz0     = mq.size();
    pop_now = !have_svc && (sz0 > 0);
    if (have_svc && cyc == t_resp) begin
      m_last_vec = int'(svc_vec);
      m_last_fnc = int'(svc_fnc);
      if (svc_fail) m_fail = sat(m_fail);
      else          m_ack  = sat(m_ack);
      have_svc = 0;
    end
    if (pop_now) begin
      e        = mq.pop_front();
      svc_vec  = e[19:8];
      svc_fnc  = e[7:0];
      svc_fail = force_f || (int'(e[7:0]) > int'(maxf));
      t_resp   = cyc + int'(dly) + 2;
      have_svc = 1;
    end
    if (vld) begin
      if (en && (sz0 < DEPTH || pop_now)) mq.push_back({vec, fnc});
      else                                m_drop = sat(m_drop);
    end
    cyc++;
  endtask

  task automatic cycle();
    bit resp_now;
    @(negedge clk);
    if (rst) model_reset();
    resp_now = have_svc && (cyc == t_resp);
    check("ack",      32'(ack),      32'(resp_now && !svc_fail));
    check("fail",     32'(fail),     32'(resp_now && svc_fail));
    check("level",    32'(level),    32'(mq.size()));
    check("busy",     32'(busy),     32'((mq.size() > 0) || have_svc));
    check("last_vec", 32'(last_vec), 32'(m_last_vec));
    check("last_fnc", 32'(last_fnc), 32'(m_last_fnc));
    check("ack_cnt",  32'(ack_cnt),  32'(m_ack));
    check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (!rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int k);
    vld = 1'b0;
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic req(input logic [11:0] v, input logic [7:0] f);
    vld = 1'b1;
    vec = v;
    fnc = f;
    cycle();
    vld = 1'b0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    #1;
    run(3);
    rst = 1'b0;
    run(2);

    dly = 8'd0; maxf = 8'd255;
    req(12'h005, 8'h01);
    run(6);
    check("t1_ack_cnt",  32'(ack_cnt),  32'd1);
    check("t1_fail_cnt", 32'(fail_cnt), 32'd0);
    check("t1_last_vec", 32'(last_vec), 32'h005);

    dly = 8'd10; maxf = 8'd3;
    req(12'h009, 8'h04);
    run(16);
    check("t2_fail_cnt", 32'(fail_cnt), 32'd1);
    check("t2_ack_cnt",  32'(ack_cnt),  32'd1);

    dly = 8'd5; maxf = 8'd255;
    for (int i = 1; i <= 6; i++) req(12'(i), 8'h02);
    run(60);
    check("t3_answered_plus_drop", 32'(ack_cnt) - 32'd1 + 32'(drop_cnt), 32'd6);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t3_last_vec", 32'(last_vec), 32'd5);

    force_f = 1'b1;
    req(12'h00a, 8'h01);
    run(3);
    force_f = 1'b0;
    req(12'h00b, 8'h01);
    run(25);
    check("t4_fail_cnt", 32'(fail_cnt), 32'd2);
    check("t4_ack_cnt",  32'(ack_cnt),  32'd7);
    check("t4_last_vec", 32'(last_vec), 32'h00b);

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(12'h0ff, 8'h00);
      run(1);
    end
    run(10);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd4);
    check("t5_ack_cnt",  32'(ack_cnt),  32'd7);

    en = 1'b1; dly = 8'd20;
    req(12'h123, 8'h01);
    req(12'h124, 8'h01);
    run(5);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(30);
    check("t5_rst_ack_cnt",  32'(ack_cnt),  32'd0);
    check("t5_rst_fail_cnt", 32'(fail_cnt), 32'd0);
    check("t5_rst_level",    32'(level),    32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 0) begin
        dly     = 8'($urandom_range(0, 6));
        maxf    = 8'($urandom_range(0, 255));
        en      = ($urandom % 8) != 0;
        force_f = ($urandom % 5) == 0;
      end
      rst = (i >= 1500 && i < 1502);
      vld = ($urandom_range(0, 99) < 40);
      vec = 12'($urandom);
      fnc = 8'($urandom);
      cycle();
    end
    rst = 1'b0;
    run(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
